// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM state encoding,
// default operand width and the iteration counter sizing.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts {P,A} left by one and
// keeps the trial difference when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH:0]   ymag,
  output logic [WIDTH:0]   p_out,
  output logic [WIDTH-1:0] a_out
);

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_sh;
  logic             unused_p_msb;

  // P stays below |y| <= 2^(WIDTH-1), so its top bit is always clear.
  assign unused_p_msb = p_in[WIDTH];

  always_comb begin
    p_sh  = {p_in[WIDTH-1:0], a_in[WIDTH-1]};
    a_sh  = {a_in[WIDTH-2:0], 1'b0};
    trial = p_sh - ymag;
    if (!trial[WIDTH]) begin
      p_out = trial;
      a_out = {a_sh[WIDTH-1:1], 1'b1};
    end else begin
      p_out = p_sh;
      a_out = a_sh;
    end
  end

endmodule

// File: rtl/div_8bit_seq.sv
// Iterative signed divider (restoring, one quotient bit per clock) with a
// start/busy/done handshake; quotient truncates toward zero.
module div_8bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r_q,
  output logic [WIDTH-1:0] r_r,
  output logic             of,
  output logic             dz
);

  // The default width reuses the package counter size; other widths derive their own.
  localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH:0]   ymag_q, ymag_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic             of_pend_q, of_pend_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             of_q, of_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             of_in;
  logic             dz_in;
  logic             cnt_last;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p_q),
    .a_in  (a_q),
    .ymag  (ymag_q),
    .p_out (p_step),
    .a_out (a_step)
  );

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign x_abs    = x[WIDTH-1] ? -x : x;
  assign y_abs    = y[WIDTH-1] ? -y : y;
  assign of_in    = (x == MIN_VAL) && (&y);
  assign dz_in    = ~|y;
  assign cnt_last = (cnt_q == CW'(WIDTH-1));
  assign quo_fix  = sign_quo_q ? -a_q : a_q;
  assign rem_fix  = sign_rem_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    a_d        = a_q;
    ymag_d     = ymag_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    of_pend_d  = of_pend_q;
    dz_pend_d  = dz_pend_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    of_d       = of_q;
    dz_d       = dz_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d        = x_abs;
          ymag_d     = {1'b0, y_abs};
          p_d        = '0;
          cnt_d      = '0;
          sign_quo_d = x[WIDTH-1] ^ y[WIDTH-1];
          sign_rem_d = x[WIDTH-1];
          of_pend_d  = of_in;
          dz_pend_d  = dz_in;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        p_d   = p_step;
        a_d   = a_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        done_d  = 1'b1;
        of_d    = of_pend_q;
        dz_d    = dz_pend_q;
        state_d = ST_IDLE;
        // A zero divisor leaves |x| in P, so the signed fix-up reproduces x.
        if (dz_pend_q) begin
          quo_d = '1;
          rem_d = rem_fix;
        end else if (of_pend_q) begin
          quo_d = MIN_VAL;
          rem_d = '0;
        end else begin
          quo_d = quo_fix;
          rem_d = rem_fix;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      a_q        <= '0;
      ymag_q     <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      of_pend_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      of_q       <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      a_q        <= a_d;
      ymag_q     <= ymag_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      of_pend_q  <= of_pend_d;
      dz_pend_q  <= dz_pend_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      of_q       <= of_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign r_q  = quo_q;
  assign r_r  = rem_q;
  assign of   = of_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div_8bit_seq.sv
// Scoreboard bench for div_8bit_seq: directed divisions push expected results,
// an independent monitor pops and compares on every done pulse.
module tb_div_8bit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic [7:0] r_q;
  logic [7:0] r_r;
  logic       of;
  logic       dz;

  typedef struct {
    logic [7:0] quo;
    logic [7:0] rem;
    logic       of_f;
    logic       dz_f;
    int         due;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic done_prev = 1'b0;

  div_8bit_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .r_q   (r_q),
    .r_r   (r_r),
    .of    (of),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called on a falling edge; issues a one-cycle start and records the expected result.
  task automatic applyStimulus(input logic [7:0] xi, input logic [7:0] yi,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic eo, input logic ed,
                               input string tag, input bit expect_done);
    exp_t e;
    x     = xi;
    y     = yi;
    start = 1'b1;
    if (expect_done) begin
      e.quo  = eq;
      e.rem  = er;
      e.of_f = eo;
      e.dz_f = ed;
      e.due  = cyc + 10;
      e.tag  = tag;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  // Monitor: compares every done pulse against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      done_prev <= 1'b0;
    end else begin
      if (done_prev) checkOutput("done_pulse_width", {31'd0, done}, 32'd0);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, required no pending division", cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput({mon_e.tag, "_quo"},     {24'd0, r_q}, {24'd0, mon_e.quo});
          checkOutput({mon_e.tag, "_rem"},     {24'd0, r_r}, {24'd0, mon_e.rem});
          checkOutput({mon_e.tag, "_of"},      {31'd0, of},  {31'd0, mon_e.of_f});
          checkOutput({mon_e.tag, "_dz"},      {31'd0, dz},  {31'd0, mon_e.dz_f});
          checkOutput({mon_e.tag, "_latency"}, cyc,          mon_e.due);
        end
      end
      done_prev <= done;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    x     = 8'd0;
    y     = 8'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_quo",  {24'd0, r_q},  32'd0);
    checkOutput("reset_rem",  {24'd0, r_r},  32'd0);
    checkOutput("reset_of",   {31'd0, of},   32'd0);
    checkOutput("reset_dz",   {31'd0, dz},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, "p100_p7", 1);
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    waitDone("p100_p7");
    // Each following division starts on the done cycle of the previous one.
    applyStimulus(8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0, "m100_p7", 1); waitDone("m100_p7");
    applyStimulus(8'd100, 8'hF9,  8'hF2,  8'h02,  1'b0, 1'b0, "p100_m7", 1); waitDone("p100_m7");
    applyStimulus(8'h80,  8'hFF,  8'h80,  8'h00,  1'b1, 1'b0, "min_m1",  1); waitDone("min_m1");
    applyStimulus(8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0, "min_p1",  1); waitDone("min_p1");
    applyStimulus(8'd5,   8'd0,   8'hFF,  8'h05,  1'b0, 1'b1, "p5_z",    1); waitDone("p5_z");
    applyStimulus(8'hFF,  8'd0,   8'hFF,  8'hFF,  1'b0, 1'b1, "m1_z",    1); waitDone("m1_z");
    applyStimulus(8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, 1'b0, "max_min", 1); waitDone("max_min");
    applyStimulus(8'h80,  8'h80,  8'h01,  8'h00,  1'b0, 1'b0, "min_min", 1); waitDone("min_min");
    applyStimulus(8'd7,   8'd100, 8'h00,  8'h07,  1'b0, 1'b0, "p7_p100", 1); waitDone("p7_p100");

    // Start held high with new operands while busy must not disturb the division.
    applyStimulus(8'd20, 8'd3, 8'd6, 8'd2, 1'b0, 1'b0, "p20_p3", 1);
    start = 1'b1;
    x     = 8'd50;
    y     = 8'd5;
    repeat (5) @(negedge clk);
    start = 1'b0;
    waitDone("p20_p3");
    applyStimulus(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0, "p9_p4", 1);
    waitDone("p9_p4");
    repeat (3) @(negedge clk);
    checkOutput("hold_quo",  {24'd0, r_q},  32'd2);
    checkOutput("hold_rem",  {24'd0, r_r},  32'd1);
    checkOutput("hold_done", {31'd0, done}, 32'd0);

    // Abort a division in its fourth cycle with an asynchronous reset.
    applyStimulus(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, "abort", 0);
    repeat (3) @(negedge clk);
    checkOutput("busy_mid_calc", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_quo",  {24'd0, r_q},  32'd0);
    checkOutput("abort_rem",  {24'd0, r_r},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("abort_no_result", {24'd0, r_q}, 32'd0);
    checkOutput("abort_idle",      {31'd0, busy}, 32'd0);
    applyStimulus(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0, "post_abort", 1);
    waitDone("post_abort");
    @(negedge clk);

    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
